// File: rtl/mips32_imem_loader.sv
// mips32_imem_loader: byte-stream program loader and combinational instruction fetch port for Mips32.
// Define MIPS32_IMEM_CHECKSUM_EN to require a trailing XOR checksum word after the image.
module mips32_imem_loader #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           raddr,
  output logic [31:0]           instr,
  output logic                  core_run,
  output logic [DEPTH_LOG2:0]   loaded,
  output logic                  error
);
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [15:0] MAX_LEN = 16'(WORDS);
  typedef enum logic [2:0] {IDLE, LEN_HI, LOAD, RUN, ERROR
`ifdef MIPS32_IMEM_CHECKSUM_EN
    , CHECK
`endif
  } state_e;
  state_e state_q, state_d;
  logic armed_q;
  logic [7:0] len_lo_q, len_lo_d;
  logic [DEPTH_LOG2:0] n_q, n_d, loaded_q, loaded_d;
  logic [1:0] idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] mem [WORDS];
  logic acc, shift, wr, last_w;
  logic [15:0] len_w;
  logic [31:0] full_w;
`ifdef MIPS32_IMEM_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif
  assign acc = in_valid & in_ready;
  assign len_w = {in_data, len_lo_q};
  // Bytes 0..2 shift in from the top so byte k lands at bits [8k+7:8k] once byte 3 arrives.
  assign full_w = {in_data, word_q};
`ifdef MIPS32_IMEM_CHECKSUM_EN
  assign shift = acc && (state_q == LOAD || state_q == CHECK);
`else
  assign shift = acc && state_q == LOAD;
`endif
  assign wr = shift && state_q == LOAD && idx_q == 2'd3;
  assign last_w = (loaded_q + 1'b1) == n_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      len_lo_q <= '0;
      n_q      <= '0;
      loaded_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
`ifdef MIPS32_IMEM_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      len_lo_q <= len_lo_d;
      n_q      <= n_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
`ifdef MIPS32_IMEM_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end
  always_ff @(posedge clock) begin
    if (wr) mem[loaded_q[DEPTH_LOG2-1:0]] <= full_w;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (acc) state_d = LEN_HI;
      LEN_HI: if (acc) state_d = (len_w == 16'd0 || len_w > MAX_LEN) ? ERROR : LOAD;
`ifdef MIPS32_IMEM_CHECKSUM_EN
      LOAD:   if (wr && last_w) state_d = CHECK;
      CHECK:  if (shift && idx_q == 2'd3) state_d = (full_w == csum_q) ? RUN : ERROR;
`else
      LOAD:   if (wr && last_w) state_d = RUN;
`endif
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    len_lo_d = (acc && state_q == IDLE) ? in_data : len_lo_q;
    n_d      = (acc && state_q == LEN_HI) ? len_w[DEPTH_LOG2:0] : n_q;
    idx_d    = shift ? idx_q + 2'd1 : idx_q;
    word_d   = shift ? {in_data, word_q[23:8]} : word_q;
    loaded_d = wr ? loaded_q + 1'b1 : loaded_q;
`ifdef MIPS32_IMEM_CHECKSUM_EN
    csum_d   = wr ? csum_q ^ full_w : csum_q;
`endif
  end
  // in_ready waits one edge after reset release so it reads 0 for the whole reset.
  always_comb begin
    in_ready = armed_q && state_q != RUN && state_q != ERROR;
    core_run = state_q == RUN;
    error    = state_q == ERROR;
    loaded   = loaded_q;
    instr    = (core_run && raddr < 32'(loaded_q)) ? mem[raddr[DEPTH_LOG2-1:0]] : 32'd0;
  end
endmodule

// File: tb/tb_mips32_imem_loader.sv
// tb_mips32_imem_loader: randomized image streams checked every cycle against a byte-list model.
module tb_mips32_imem_loader;
  localparam int D = 6;
  localparam int W = 1 << D;
`ifdef MIPS32_IMEM_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [31:0] raddr = '0;
  logic in_ready, core_run, error;
  logic [31:0] instr;
  logic [D:0] loaded;
  int total = 0, bad = 0;
  logic [7:0] img[$];
  bit armed = 1'b0;

  mips32_imem_loader #(.DEPTH_LOG2(D)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .raddr(raddr), .instr(instr), .core_run(core_run),
    .loaded(loaded), .error(error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input int i);
    return {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
  endfunction

  // Expected outputs derived from the list of bytes accepted since reset.
  function automatic void model(output bit rdy, output bit run, output bit err,
                                output int ld, output logic [31:0] ins);
    int s, n, need;
    logic [31:0] x;
    rdy = 0; run = 0; err = 0; ld = 0; ins = '0;
    if (!reset_n || !armed) return;
    rdy = 1;
    s = img.size();
    if (s < 2) return;
    n = int'(img[0]) + 256 * int'(img[1]);
    if (n == 0 || n > W) begin rdy = 0; err = 1; return; end
    ld = (s - 2) / 4;
    if (ld > n) ld = n;
    need = 2 + 4 * n;
    if (CS && s >= need + 4) begin
      x = '0;
      for (int i = 0; i < n; i++) x ^= word_at(i);
      run = (x == word_at(n));
      err = !run;
      rdy = 0;
    end else if (!CS && s >= need) begin
      run = 1;
      rdy = 0;
    end
    if (run && raddr < 32'(ld)) ins = word_at(int'(raddr));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin : mdl
    bit r, a, e;
    int l;
    logic [31:0] i;
    if (!reset_n) begin
      img.delete();
      armed = 1'b0;
    end else begin
      model(r, a, e, l, i);
      if (r && in_valid) img.push_back(in_data);
      armed = 1'b1;
    end
  end

  always @(negedge clock) begin : cmp
    bit r, a, e;
    int l;
    logic [31:0] i;
    model(r, a, e, l, i);
    chk("in_ready", 32'(in_ready), 32'(r));
    chk("core_run", 32'(core_run), 32'(a));
    chk("error", 32'(error), 32'(e));
    chk("loaded", 32'(loaded), 32'(l));
    chk("instr", instr, i);
  end

  task automatic tick();
    @(negedge clock);
    #1;
    raddr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 70));
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    in_valid = 1'b1;
    in_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
  endtask

  task automatic send_len(input int n);
    send(8'(n));
    send(8'(n >> 8));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_run", 32'(core_run), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_instr", instr, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(nm, instr, exp);
  endtask

  task automatic random_image();
    logic [7:0] bs[$];
    logic [31:0] w, x;
    int n, nn, abort;
    do_reset();
    if ($urandom_range(0, 9) == 0) n = $urandom_range(0, 1) ? 0 : $urandom_range(65, 65535);
    else n = $urandom_range(1, W);
    bs.push_back(8'(n));
    bs.push_back(8'(n >> 8));
    nn = (n >= 1 && n <= W) ? n : 1;
    x = '0;
    for (int i = 0; i < nn; i++) begin
      w = $urandom;
      x ^= w;
      for (int k = 0; k < 4; k++) bs.push_back(w[8*k +: 8]);
    end
    if (CS) begin
      if ($urandom_range(0, 3) == 0) x ^= 32'(1) << $urandom_range(0, 31);
      for (int k = 0; k < 4; k++) bs.push_back(x[8*k +: 8]);
    end
    abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, bs.size() - 1) : -1;
    for (int k = 0; k < bs.size(); k++) begin
      if (k == abort) begin
        do_reset();
        break;
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(bs[k]);
    end
    repeat (40) begin
      tick();
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
    end
  endtask

  initial begin
    tick();
    tick();
    reset_n = 1'b1;
    send_len(2);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    idle(3);
    send(8'h12);
    send_word(32'h0000000D);
    if (CS) send_word(32'h12345675);
    #1;
    chk("run_before_last", 32'(core_run), 32'd0);
    @(posedge clock);
    #1;
    chk("run_after_last", 32'(core_run), 32'd1);
    chk("loaded_plan", 32'(loaded), 32'd2);
    chk("ready_run", 32'(in_ready), 32'd0);
    idle(1);
    peek("plan_i0", 32'd0, 32'h12345678);
    peek("plan_i1", 32'd1, 32'h0000000D);
    peek("plan_i2", 32'd2, 32'h00000000);
    do_reset();
    send_len(0);
    @(posedge clock);
    #1;
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_ready", 32'(in_ready), 32'd0);
    chk("len0_run", 32'(core_run), 32'd0);
    do_reset();
    send_len(65);
    @(posedge clock);
    #1;
    chk("len65_error", 32'(error), 32'd1);
    chk("len65_ready", 32'(in_ready), 32'd0);
    do_reset();
    send_len(2);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    do_reset();
    send_len(1);
    send_word(32'hDDCCBBAA);
    if (CS) send_word(32'hDDCCBBAA);
    idle(2);
    chk("reload_loaded", 32'(loaded), 32'd1);
    peek("reload_i0", 32'd0, 32'hDDCCBBAA);
    peek("reload_i1", 32'd1, 32'd0);
`ifdef MIPS32_IMEM_CHECKSUM_EN
    do_reset();
    send_len(2);
    send_word(32'h0000000F);
    send_word(32'h000000F0);
    send_word(32'h000000FF);
    idle(1);
    chk("cs_good_run", 32'(core_run), 32'd1);
    do_reset();
    send_len(2);
    send_word(32'h0000000F);
    send_word(32'h000000F0);
    send_word(32'h00000000);
    idle(1);
    chk("cs_bad_error", 32'(error), 32'd1);
    peek("cs_bad_instr", 32'd0, 32'd0);
`endif
    repeat (30) random_image();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
